// File: rtl/serial_pattern_pkg.sv
// ---------------------------------------------------------------------------
// serial_pattern_pkg
// Shared definitions for the serial pattern transmitter:
//   - state_t        : 3-bit FSM state type
//   - ST_*           : state encodings (IDLE=000 .. DONE=100)
//   - DEFAULT_PATTERN: built-in pattern used when none is supplied
// ---------------------------------------------------------------------------
package serial_pattern_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'b000;
  localparam state_t ST_SEND = 3'b001;
  localparam state_t ST_GAPW = 3'b010;
  localparam state_t ST_PAR  = 3'b011;
  localparam state_t ST_DONE = 3'b100;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;

endpackage

// File: rtl/tx_shift_reg.sv
// ---------------------------------------------------------------------------
// tx_shift_reg
// PAT_W-bit left-shifting register with a bit counter that marks the last
// bit of the loaded word.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (clears register and counter)
//   load  : load din and restart the bit counter (priority over shift)
//   shift : shift left by one and count down
//   din   : word to load
//   msb   : current most significant bit (the bit on the line)
//   last  : high while the final bit of the word is at the MSB
// ---------------------------------------------------------------------------
module tx_shift_reg #(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb,
  output logic             last
);

  localparam int CNT_W = $clog2(PAT_W);

  logic [PAT_W-1:0] r_sreg;
  logic [CNT_W-1:0] r_bcnt;

  // Shift register and bit counter: load wins over shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_bcnt <= '0;
    end else if (load) begin
      r_sreg <= din;
      r_bcnt <= CNT_W'(PAT_W - 1);
    end else if (shift) begin
      r_sreg <= {r_sreg[PAT_W-2:0], 1'b0};
      r_bcnt <= r_bcnt - CNT_W'(1);
    end
  end

  assign msb  = r_sreg[PAT_W-1];
  assign last = (r_bcnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
// Moore FSM that serialises a pattern MSB first, REPEAT times with GAP idle
// cycles between copies, then waits in DONE for an acknowledge.
// Optional feature: define SERIAL_PATTERN_TX_PARITY_EN to append one even
// parity bit (XOR of the pattern bits) after the final copy.
// Parameters: PAT_W, PATTERN, REPEAT (1..15), GAP (0..7)
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   start  : start request, sampled only in IDLE
//   ld     : with an accepted start, selects pat_in instead of PATTERN
//   pat_in : run-time pattern
//   cntrl  : completion acknowledge, sampled only in DONE
//   j      : serial data bit
//   j_vld  : j carries a pattern/parity bit
//   busy   : high in every state except IDLE
//   done   : transmission complete, held until acknowledged
// ---------------------------------------------------------------------------
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               REPEAT  = 1,
  parameter int               GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cntrl,
  output logic             j,
  output logic             j_vld,
  output logic             busy,
  output logic             done
);

  if (PAT_W < 2 || REPEAT < 1 || REPEAT > 15 || GAP < 0 || GAP > 7) begin : g_param_check
    $error("serial_pattern_tx: parameter out of range");
  end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam state_t ST_AFTER_LAST = ST_PAR;
`else
  localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [3:0]       r_copy;
  logic [2:0]       r_gap;
  logic             w_load;
  logic             w_shift;
  logic [PAT_W-1:0] w_din;
  logic             w_msb;
  logic             w_last;

  tx_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .msb   (w_msb),
    .last  (w_last)
  );

  // Next-state decode and shift register control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_din       = r_pat;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_din       = ld ? pat_in : PATTERN;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!w_last) begin
          w_shift = 1'b1;
        end else if (r_copy != 4'd0) begin
          if (GAP > 0) begin
            w_state_nxt = ST_GAPW;
          end else begin
            // No gap: reload the latched pattern and keep sending.
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end else begin
          w_state_nxt = ST_AFTER_LAST;
        end
      end
      ST_GAPW: begin
        if (r_gap == 3'd0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_GAPW;
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      ST_PAR: begin
        w_state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (cntrl) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, latched pattern, copy and gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_copy  <= 4'd0;
      r_gap   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start) begin
        r_pat  <= w_din;
        r_copy <= 4'(REPEAT - 1);
      end
      if (r_state == ST_SEND && w_last && r_copy != 4'd0) begin
        r_copy <= r_copy - 4'd1;
        // Gap counter runs GAP-1 .. 0, giving exactly GAP idle cycles.
        r_gap  <= (GAP > 0) ? 3'(GAP - 1) : 3'd0;
      end
      if (r_state == ST_GAPW && r_gap != 3'd0) begin
        r_gap <= r_gap - 3'd1;
      end
    end
  end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  function automatic logic f_even_parity(input logic [PAT_W-1:0] v);
    return ^v;
  endfunction

  logic w_par;
  assign w_par = f_even_parity(r_pat);
  assign j     = ((r_state == ST_SEND) & w_msb) | ((r_state == ST_PAR) & w_par);
  assign j_vld = (r_state == ST_SEND) | (r_state == ST_PAR);
`else
  assign j     = (r_state == ST_SEND) & w_msb;
  assign j_vld = (r_state == ST_SEND);
`endif

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
// Three transmitter instances (default; REPEAT=2/GAP=2; REPEAT=3/GAP=0 with
// a different built-in pattern) driven by randomized transactions. The
// expected per-cycle {j_vld, j, busy, done} stream is built from the
// transmission rules: REPEAT copies MSB first, GAP idle cycles between
// copies, optional parity bit, then DONE until acknowledged.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start_a  [3];
  logic       ld_a     [3];
  logic [4:0] pat_in_a [3];
  logic       cntrl_a  [3];
  logic       j_a      [3];
  logic       vld_a    [3];
  logic       busy_a   [3];
  logic       done_a   [3];

  int n_run  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  serial_pattern_tx dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .ld(ld_a[0]), .pat_in(pat_in_a[0]),
    .cntrl(cntrl_a[0]), .j(j_a[0]), .j_vld(vld_a[0]), .busy(busy_a[0]), .done(done_a[0]));

  serial_pattern_tx #(.REPEAT(2), .GAP(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .ld(ld_a[1]), .pat_in(pat_in_a[1]),
    .cntrl(cntrl_a[1]), .j(j_a[1]), .j_vld(vld_a[1]), .busy(busy_a[1]), .done(done_a[1]));

  serial_pattern_tx #(.PATTERN(5'b01101), .REPEAT(3), .GAP(0)) dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .ld(ld_a[2]), .pat_in(pat_in_a[2]),
    .cntrl(cntrl_a[2]), .j(j_a[2]), .j_vld(vld_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference stream: {vld, j, busy, done} for each cycle after start.
  task automatic build_exp(input logic [4:0] pat, input int rep, input int gap, input int ndone);
    exp_q.delete();
    for (int k = 0; k < rep; k++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
      if (k < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    if (PAR_BITS == 1) exp_q.push_back({1'b1, ^pat, 1'b1, 1'b0});
    for (int d = 0; d < ndone; d++) exp_q.push_back(4'b0011);
  endtask

  task automatic kick(input int idx, input logic use_ld, input logic [4:0] pat);
    start_a[idx]  = 1'b1;
    ld_a[idx]     = use_ld;
    pat_in_a[idx] = pat;
    @(negedge clk);
    start_a[idx] = 1'b0;
    ld_a[idx]    = 1'b0;
  endtask

  // mode 0: quiet inputs; 1: random noise on start/ld/pat_in (and cntrl
  // while surely in SEND); 2: pat_in forced to 11111 with ld=1 in cycle 2.
  task automatic capture(input int idx, input int ncyc, input int mode);
    obs_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      obs_q.push_back({vld_a[idx], j_a[idx], busy_a[idx], done_a[idx]});
      if (mode == 1) begin
        pat_in_a[idx] = 5'($urandom);
        ld_a[idx]     = 1'($urandom);
        start_a[idx]  = 1'($urandom);
        cntrl_a[idx]  = (c < 3) ? 1'($urandom) : 1'b0;
      end else if (mode == 2 && c == 0) begin
        pat_in_a[idx] = 5'b11111;
        ld_a[idx]     = 1'b1;
      end
      @(negedge clk);
    end
    start_a[idx] = 1'b0;
    ld_a[idx]    = 1'b0;
    cntrl_a[idx] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; ld_a[i] = 1'b0; pat_in_a[i] = 5'd0; cntrl_a[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if ({vld_a[i], j_a[i], busy_a[i], done_a[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset dut%0d vld,j,busy,done got %b exp 0000", i,
                 {vld_a[i], j_a[i], busy_a[i], done_a[i]});
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_pattern;
    for (int it = 0; it < 3; it++) begin
      kick(0, 1'b0, 5'($urandom));
      build_exp(5'b10110, 1, 2, 1 + int'($urandom_range(0, 3)));
      capture(0, exp_q.size(), 1);
      for (int c = 0; c < exp_q.size(); c++) begin
        n_run++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          $display("FAIL default it%0d cyc%0d vld,j,busy,done got %b exp %b", it, c + 1, obs_q[c], exp_q[c]);
        end
      end
      cntrl_a[0] = 1'b1;
      @(negedge clk);
      cntrl_a[0] = 1'b0;
      n_run++;
      if ({busy_a[0], done_a[0], vld_a[0]} !== 3'b000) begin
        n_fail++;
        $display("FAIL default_ack it%0d busy,done,vld got %b exp 000", it, {busy_a[0], done_a[0], vld_a[0]});
      end
    end
  endtask

  task automatic test_ld_pattern;
    for (int it = 0; it < 4; it++) begin
      logic [4:0] p;
      p = (it == 0) ? 5'b01001 : 5'($urandom);
      kick(0, 1'b1, p);
      build_exp(p, 1, 2, 1);
      capture(0, exp_q.size(), (it == 0) ? 2 : 1);
      for (int c = 0; c < exp_q.size(); c++) begin
        n_run++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          $display("FAIL ld_pattern pat=%b cyc%0d got %b exp %b", p, c + 1, obs_q[c], exp_q[c]);
        end
      end
      cntrl_a[0] = 1'b1;
      @(negedge clk);
      cntrl_a[0] = 1'b0;
    end
  endtask

  task automatic test_repeat_gap;
    for (int it = 0; it < 3; it++) begin
      logic [4:0] p;
      int nv;
      p = (it == 0) ? 5'b10110 : 5'($urandom);
      kick(1, (it != 0), p);
      build_exp(p, 2, 2, 2);
      capture(1, exp_q.size(), 1);
      nv = 0;
      for (int c = 0; c < exp_q.size(); c++) begin
        if (obs_q[c][3]) nv++;
        n_run++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          $display("FAIL repeat_gap pat=%b cyc%0d got %b exp %b", p, c + 1, obs_q[c], exp_q[c]);
        end
      end
      n_run++;
      if (nv != 2 * 5 + PAR_BITS) begin
        n_fail++;
        $display("FAIL repeat_gap_vld_count got %0d exp %0d", nv, 2 * 5 + PAR_BITS);
      end
      cntrl_a[1] = 1'b1;
      @(negedge clk);
      cntrl_a[1] = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 3; it++) begin
      logic [4:0] p;
      p = (it == 0) ? 5'b01101 : 5'($urandom);
      kick(2, (it != 0), p);
      build_exp(p, 3, 0, 1);
      capture(2, exp_q.size(), 1);
      for (int c = 0; c < exp_q.size(); c++) begin
        n_run++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          $display("FAIL back_to_back pat=%b cyc%0d got %b exp %b", p, c + 1, obs_q[c], exp_q[c]);
        end
      end
      cntrl_a[2] = 1'b1;
      @(negedge clk);
      cntrl_a[2] = 1'b0;
    end
  endtask

  task automatic test_done_start_cntrl;
    logic [4:0] p;
    p = 5'($urandom);
    kick(0, 1'b1, p);
    build_exp(p, 1, 2, 4);
    capture(0, exp_q.size(), 0);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_run++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        $display("FAIL done_hold cyc%0d got %b exp %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    start_a[0] = 1'b1;
    cntrl_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    cntrl_a[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_run++;
      if ({busy_a[0], done_a[0], vld_a[0]} !== 3'b000) begin
        n_fail++;
        $display("FAIL start_cntrl_in_done cyc%0d busy,done,vld got %b exp 000", c, {busy_a[0], done_a[0], vld_a[0]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    logic [4:0] p;
    p = 5'b10110;
    kick(0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if ({vld_a[0], j_a[0]} !== {1'b1, p[2]}) begin
      n_fail++;
      $display("FAIL async_reset_third_bit vld,j got %b exp %b", {vld_a[0], j_a[0]}, {1'b1, p[2]});
    end
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if ({vld_a[i], j_a[i], busy_a[i], done_a[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_reset_immediate dut%0d got %b exp 0000", i, {vld_a[i], j_a[i], busy_a[i], done_a[i]});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    kick(0, 1'b0, 5'($urandom));
    build_exp(p, 1, 2, 1);
    capture(0, exp_q.size(), 1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_run++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        $display("FAIL after_reset cyc%0d got %b exp %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    cntrl_a[0] = 1'b1;
    @(negedge clk);
    cntrl_a[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_ld_pattern();
    test_repeat_gap();
    test_back_to_back();
    test_done_start_cntrl();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
